// File: rtl/dmem_arbiter_if.sv
// Bundle of CPU MEM-stage, debug/loader and data-memory signals for dmem_arbiter.
// slave = arbiter side, master = requesters + memory side.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_ack;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_rdata, dbg_ack,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_rdata, dbg_ack,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares the data-memory port between the CPU MEM stage and a debug/loader port.
// Debug port and round-robin arbitration exist only when DMEM_ARB_DBG_EN is defined.
//
// state | meaning
// IDLE  | sample requests, latch the winner's access
// BUSY  | memory access, counter runs WAIT_CYCLES-1 .. 0
// DONE  | one cycle, acknowledge / unstall the owner
module dmem_arbiter #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input logic          clk,
  input logic          rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  localparam logic       SINGLE   = (WAIT_CYCLES == 1);

  state_t            state;
  logic [3:0]        cnt;
  logic              owner;
  logic              req_we;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              mem_read_q;
  logic              mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic              any_req;
  logic              grant_dbg;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

`ifdef DMEM_ARB_DBG_EN
  logic              last_owner;
  logic [DATA_W-1:0] dbg_rdata_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_dbg = bus.dbg_req;
    if (bus.cpu_req && bus.dbg_req)
      grant_dbg = !last_owner;
  end

  assign any_req = bus.cpu_req | bus.dbg_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      last_owner <= 1'b1;
    else if (state == DONE)
      last_owner <= owner;
  end

  assign bus.dbg_rdata = dbg_rdata_q;
  assign bus.dbg_ack   = (state == DONE) && owner;
`else
  logic unused_dbg;

  assign grant_dbg     = 1'b0;
  assign any_req       = bus.cpu_req;
  assign unused_dbg    = ^{bus.dbg_req, bus.dbg_we, bus.dbg_addr, bus.dbg_wdata};
  assign bus.dbg_rdata = '0;
  assign bus.dbg_ack   = 1'b0;
`endif

  assign sel_we    = grant_dbg ? bus.dbg_we    : bus.cpu_we;
  assign sel_addr  = grant_dbg ? bus.dbg_addr  : bus.cpu_addr;
  assign sel_wdata = grant_dbg ? bus.dbg_wdata : bus.cpu_wdata;

  // mem_* are registered, so the write strobe is set one edge ahead of cnt==0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      owner       <= 1'b0;
      req_we      <= 1'b0;
      cpu_rdata_q <= '0;
`ifdef DMEM_ARB_DBG_EN
      dbg_rdata_q <= '0;
`endif
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= BUSY;
            cnt         <= CNT_INIT;
            owner       <= grant_dbg;
            req_we      <= sel_we;
            mem_read_q  <= !sel_we;
            mem_write_q <= sel_we && SINGLE;
            mem_addr_q  <= sel_addr;
            mem_wdata_q <= sel_wdata;
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            if (!req_we) begin
`ifdef DMEM_ARB_DBG_EN
              if (owner)
                dbg_rdata_q <= bus.mem_rdata;
              else
                cpu_rdata_q <= bus.mem_rdata;
`else
              cpu_rdata_q <= bus.mem_rdata;
`endif
            end
            state       <= DONE;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
          end else begin
            cnt         <= cnt - 4'd1;
            mem_write_q <= req_we && (cnt == 4'd1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_stall = bus.cpu_req && !((state == DONE) && !owner);
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the pipeline's data memory. It sits between the MEM stage and the data memory array, and shares the single memory port between the CPU MEM stage and a debug/loader port. Each access runs a fixed number of wait cycles. The block stalls the pipeline until the CPU's access completes and grants turns round-robin when both requesters are active.

## Interface
- `WAIT_CYCLES`, 1: memory access cycles per transaction; legal range 1..15.
- `ADDR_W`, 32: address width (byte address).
- `DATA_W`, 32: data width.

- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `cpu_req`  in  1  MEM-stage access request (MemRead | MemWrite); held until ack.
- `cpu_we`  in  1  1 = write, 0 = read.
- `cpu_addr`  in  ADDR_W  byte address.
- `cpu_wdata`  in  DATA_W  store data.
- `cpu_rdata`  out  DATA_W  load data, registered.
- `cpu_stall`  out  1  freeze pipeline.
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_wdata`  in  1/1/ADDR_W/DATA_W  debug request, same semantics as the CPU inputs.
- `dbg_rdata`  out  DATA_W  debug load data, registered.
- `dbg_ack`  out  1  one-cycle completion pulse.
- `mem_read`, `mem_write`  out  1  drive the data memory's MemRead/MemWrite.
- `mem_addr`  out  ADDR_W  address to memory.
- `mem_wdata`  out  DATA_W  write data to memory.
- `mem_rdata`  in  DATA_W  combinational memory read data.

## Operation
- FSM states:
  - IDLE: sample requests.
  - BUSY: count down `WAIT_CYCLES`.
  - DONE: one cycle; acknowledge the owner.
- IDLE:
  - If any request is active, latch the owner (`owner`: 0 = CPU, 1 = DBG) plus that owner's `we`/`addr`/`wdata` into request registers.
  - Load the counter with `WAIT_CYCLES-1` and go to BUSY.
- Arbitration:
  - With a single request, that requester wins.
  - With both requests active, the requester other than `last_owner` wins.
  - `last_owner` resets to 1 (DBG), so the CPU wins the first tie.
- BUSY:
  - `mem_addr`/`mem_wdata` come from the latched registers.
  - `mem_read` = !we for every BUSY cycle.
  - `mem_write` = we only in the final BUSY cycle (counter == 0), so exactly one memory write per transaction.
  - In the final cycle, capture `mem_rdata` into the owner's rdata register (reads only), then go to DONE.
  - Otherwise decrement the counter.
- DONE: update `last_owner` <= `owner`; return to IDLE. Requests are never granted directly from DONE.
- `cpu_stall` = `cpu_req` && !(state==DONE && owner==CPU), combinational. The stall drops in the DONE cycle so the pipeline advances on the following edge.
- `dbg_ack` = (state==DONE && owner==DBG).
- Request inputs are ignored outside IDLE. A request dropped mid-transaction does not abort the transaction.
- Outside BUSY: `mem_read` = `mem_write` = 0 and `mem_addr` = 0.
- `mem_addr` is passed unmodified. The memory ignores bits [1:0]; misalignment is not checked.

## Timing
- Reset values: state = IDLE, `cpu_stall` = `cpu_req` (combinational), `dbg_ack` = 0, `cpu_rdata` = `dbg_rdata` = 0, `mem_read` = `mem_write` = 0, `mem_addr` = `mem_wdata` = 0, `last_owner` = 1.
- Request sampled at edge k:
  - BUSY during cycles k+1..k+WAIT_CYCLES.
  - DONE (ack/unstall) in cycle k+WAIT_CYCLES+1.
  - rdata valid from cycle k+WAIT_CYCLES+1.
- Back-to-back transactions start every `WAIT_CYCLES`+2 cycles.
- Reset asserted mid-BUSY returns to IDLE immediately. If reset arrives before the final BUSY cycle's edge, no memory write occurs.

## Configuration
- `DMEM_ARB_DBG_EN` defined: debug port and round-robin arbitration are present as described above.
- `DMEM_ARB_DBG_EN` undefined:
  - The debug inputs are ignored.
  - `dbg_ack` = 0 and `dbg_rdata` = 0 constantly.
  - `owner` is always CPU and the `last_owner` logic is removed.
  - Latency is unchanged.

## Test plan
- CPU read, `WAIT_CYCLES`=2, memory word 250 = 0x0000_00AB: request at edge 0 -> `mem_read` high cycles 1–2, `cpu_stall` low in cycle 3, `cpu_rdata` = 0xAB from cycle 3.
- CPU write 0x1234 to address 0x3E8 (`WAIT_CYCLES`=3): `mem_write` high only in cycle 3, memory word 250 = 0x1234 after it, single write observed.
- `cpu_req` and `dbg_req` both high at reset release -> CPU served first. DBG is served next, and `dbg_ack` pulses `WAIT_CYCLES`+2 cycles after CPU DONE. Alternation continues while both stay high.
- Reset asserted in the first BUSY cycle of a write (`WAIT_CYCLES`=3) -> no `mem_write` pulse, state IDLE, the request re-arbitrates after release.
- `dbg_req` only, with `DMEM_ARB_DBG_EN` undefined -> no memory activity, `dbg_ack` stays 0. The CPU's concurrent read completes with normal latency.
